// File: rtl/cpu_pkg.sv
// Shared definitions for the single-cycle RISC-V system: the run-controller
// state encoding and the default end-of-program PC used by the system top.
package cpu_pkg;

  typedef logic [1:0] run_state_t;

  localparam run_state_t ST_IDLE   = 2'd0;
  localparam run_state_t ST_RUN    = 2'd1;
  localparam run_state_t ST_STEP   = 2'd2;
  localparam run_state_t ST_HALTED = 2'd3;

  // Fetching this address means the program has finished.
  localparam logic [31:0] CPU_LAST_PC_DEFAULT = 32'hFFFF_FFFE;

endpackage

// File: rtl/sat_counter.sv
// Up-counter that sticks at all-ones instead of wrapping, so a long run
// still reports "at least this many" rather than a small bogus value.
module sat_counter #(
  parameter int W = 32
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic         i_inc,
  output logic [W-1:0] o_count
);

  logic [W-1:0] r_count;

  // Count qualified events, saturating at the maximum value.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_count <= '0;
    end else if (i_inc && (r_count != {W{1'b1}})) begin
      r_count <= r_count + W'(1);
    end
  end

  assign o_count = r_count;

endmodule

// File: rtl/cpu_run_ctrl.sv
// Run/halt controller for the single-cycle core. It decides, cycle by
// cycle, whether the core may commit (core_en), handles free-run and
// single-step, stops at the end-of-program PC, enforces a watchdog on
// executed cycles and keeps saturating cycle/store counters.
module cpu_run_ctrl
  import cpu_pkg::*;
#(
  parameter int              XLEN    = 32,
  parameter logic [XLEN-1:0] LAST_PC = XLEN'(CPU_LAST_PC_DEFAULT),
  parameter int              CNT_W   = 32,
  parameter int unsigned     TIMEOUT = 1000000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             run_req,
  input  logic             step_req,
  input  logic             halt_req,
  input  logic [XLEN-1:0]  instr_addr,
  input  logic             ram_we,
  output logic             core_en,
  output logic [1:0]       state,
  output logic             halted,
  output logic             timeout,
  output logic [CNT_W-1:0] cycle_cnt,
  output logic [CNT_W-1:0] store_cnt
);

  // The watchdog compare is done at 64 bits so a TIMEOUT larger than the
  // counter range simply never fires instead of being truncated.
  localparam logic [63:0] TIMEOUT_M1 = 64'(TIMEOUT) - 64'd1;

  run_state_t r_state;
  logic       r_timeout;

  run_state_t w_nextState;
  logic       w_nextTimeout;
  logic       w_pcEnd;
  logic       w_coreEn;
  logic       w_storeEn;
  logic       w_watchdogHit;
  logic [63:0] w_cycleWide;

  assign w_pcEnd     = (instr_addr == LAST_PC);
  assign w_coreEn    = !rst && ((r_state == ST_RUN) || (r_state == ST_STEP)) && !w_pcEnd;
  assign w_storeEn   = w_coreEn && ram_we;
  assign w_cycleWide = 64'(cycle_cnt);

  // This cycle is the TIMEOUT-th executed one when the count before it
  // is TIMEOUT-1.
  assign w_watchdogHit = (TIMEOUT != 0) && w_coreEn && (w_cycleWide == TIMEOUT_M1);

  // Next-state decision; halt beats end-of-program beats watchdog.
  always_comb begin
    w_nextState   = r_state;
    w_nextTimeout = r_timeout;
    case (r_state)
      ST_IDLE: begin
        if (halt_req) begin
          w_nextState = ST_HALTED;
        end else if (w_pcEnd) begin
          w_nextState = ST_HALTED;
        end else if (run_req) begin
          w_nextState = ST_RUN;
        end else if (step_req) begin
          w_nextState = ST_STEP;
        end
      end
      ST_RUN: begin
        if (halt_req || w_pcEnd) begin
          w_nextState = ST_HALTED;
        end else if (w_watchdogHit) begin
          w_nextState   = ST_HALTED;
          w_nextTimeout = 1'b1;
        end
      end
      ST_STEP: begin
        if (halt_req || w_pcEnd) begin
          w_nextState = ST_HALTED;
        end else if (w_watchdogHit) begin
          w_nextState   = ST_HALTED;
          w_nextTimeout = 1'b1;
        end else begin
          w_nextState = ST_IDLE;
        end
      end
      ST_HALTED: begin
        w_nextState = ST_HALTED;
      end
      default: begin
        w_nextState = ST_IDLE;
      end
    endcase
  end

  // State and sticky timeout flag; reset wins over any request.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= ST_IDLE;
      r_timeout <= 1'b0;
    end else begin
      r_state   <= w_nextState;
      r_timeout <= w_nextTimeout;
    end
  end

  sat_counter #(.W(CNT_W)) u_cycleCnt (
    .i_clk   (clk),
    .i_rst   (rst),
    .i_inc   (w_coreEn),
    .o_count (cycle_cnt)
  );

  sat_counter #(.W(CNT_W)) u_storeCnt (
    .i_clk   (clk),
    .i_rst   (rst),
    .i_inc   (w_storeEn),
    .o_count (store_cnt)
  );

  assign core_en = w_coreEn;
  assign state   = r_state;
  assign halted  = !rst && (r_state == ST_HALTED);
  assign timeout = r_timeout;

endmodule

// File: tb/tb_cpu_run_ctrl.sv
// Bench for cpu_run_ctrl: a vector table covering reset, free-run to the
// last PC, single-step and run/step/halt priority, plus hand-written
// sequences for the watchdog, late halt, mid-run reset and saturation.
module tb_cpu_run_ctrl;

  localparam logic [31:0] LAST = 32'hFFFF_FFFE;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        run_req = 1'b0;
  logic        step_req = 1'b0;
  logic        halt_req = 1'b0;
  logic [31:0] instr_addr = 32'd0;
  logic        ram_we = 1'b0;

  logic        en0, hl0, to0;
  logic [1:0]  st0;
  logic [31:0] cc0, sc0;
  logic        en1, hl1, to1;
  logic [1:0]  st1;
  logic [31:0] cc1, sc1;
  logic        en2, hl2, to2;
  logic [1:0]  st2;
  logic [2:0]  cc2, sc2;

  int compareCount  = 0;
  int mismatchCount = 0;

  always #5 clk = ~clk;

  cpu_run_ctrl #(.XLEN(32), .LAST_PC(LAST), .CNT_W(32), .TIMEOUT(1000000)) dut0 (
    .clk(clk), .rst(rst), .run_req(run_req), .step_req(step_req), .halt_req(halt_req),
    .instr_addr(instr_addr), .ram_we(ram_we), .core_en(en0), .state(st0), .halted(hl0),
    .timeout(to0), .cycle_cnt(cc0), .store_cnt(sc0));

  cpu_run_ctrl #(.XLEN(32), .LAST_PC(LAST), .CNT_W(32), .TIMEOUT(10)) dut1 (
    .clk(clk), .rst(rst), .run_req(run_req), .step_req(step_req), .halt_req(halt_req),
    .instr_addr(instr_addr), .ram_we(ram_we), .core_en(en1), .state(st1), .halted(hl1),
    .timeout(to1), .cycle_cnt(cc1), .store_cnt(sc1));

  cpu_run_ctrl #(.XLEN(32), .LAST_PC(LAST), .CNT_W(3), .TIMEOUT(1000000)) dut2 (
    .clk(clk), .rst(rst), .run_req(run_req), .step_req(step_req), .halt_req(halt_req),
    .instr_addr(instr_addr), .ram_we(ram_we), .core_en(en2), .state(st2), .halted(hl2),
    .timeout(to2), .cycle_cnt(cc2), .store_cnt(sc2));

  typedef struct {
    logic        rst, run, step, halt, we;
    logic [31:0] addr;
    logic        chk;
    logic        en;
    logic [1:0]  st;
    logic        hl, to;
    logic [31:0] cc, sc;
  } vec_t;

  vec_t vecs[30];

  function automatic vec_t mk(input logic r, input logic ru, input logic s, input logic h,
                              input logic w, input logic [31:0] a, input logic c,
                              input logic e, input logic [1:0] st, input logic hl,
                              input logic to, input logic [31:0] cc, input logic [31:0] sc);
    vec_t v;
    v.rst = r; v.run = ru; v.step = s; v.halt = h; v.we = w; v.addr = a; v.chk = c;
    v.en = e; v.st = st; v.hl = hl; v.to = to; v.cc = cc; v.sc = sc;
    return v;
  endfunction

  // Compare one observed value against its expected value and tally it.
  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    compareCount++;
    if (actual !== expected) begin
      mismatchCount++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
    end
  endtask

  // Drive one table row's inputs.
  task automatic applyStimulus(input vec_t v);
    rst        = v.rst;
    run_req    = v.run;
    step_req   = v.step;
    halt_req   = v.halt;
    ram_we     = v.we;
    instr_addr = v.addr;
  endtask

  // One reset cycle, leaving all inputs idle at a falling edge.
  task automatic doReset;
    @(negedge clk);
    run_req = 0; step_req = 0; halt_req = 0; ram_we = 0; instr_addr = 32'd0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  // Global time limit so the bench always ends.
  initial begin
    #200000;
    $display("[TB] FAIL time_limit: got expired, expected finish");
    $fatal(1, "[TB] time limit reached");
  end

  initial begin
    int n;
    vecs[0]  = mk(0,0,0,0,0, 32'd0, 1, 0,2'd0,0,0, 0,0);
    vecs[1]  = mk(0,0,0,0,0, 32'd0, 1, 0,2'd0,0,0, 0,0);
    vecs[2]  = mk(0,0,0,0,0, 32'd0, 1, 0,2'd0,0,0, 0,0);
    vecs[3]  = mk(0,0,0,0,0, 32'd0, 1, 0,2'd0,0,0, 0,0);
    vecs[4]  = mk(0,0,0,0,0, 32'd0, 1, 0,2'd0,0,0, 0,0);
    vecs[5]  = mk(0,1,0,0,0, 32'd0, 1, 0,2'd0,0,0, 0,0);
    vecs[6]  = mk(0,0,0,0,0, 32'd0, 1, 1,2'd1,0,0, 0,0);
    vecs[7]  = mk(0,0,0,0,0, 32'd4, 1, 1,2'd1,0,0, 1,0);
    vecs[8]  = mk(0,0,0,0,1, 32'd8, 1, 1,2'd1,0,0, 2,0);
    vecs[9]  = mk(0,0,0,0,0, LAST,  1, 0,2'd1,0,0, 3,1);
    vecs[10] = mk(0,0,0,0,0, LAST,  1, 0,2'd3,1,0, 3,1);
    vecs[11] = mk(0,1,0,0,0, 32'd0, 1, 0,2'd3,1,0, 3,1);
    vecs[12] = mk(0,0,1,0,0, 32'd0, 1, 0,2'd3,1,0, 3,1);
    vecs[13] = mk(1,0,0,0,0, 32'd0, 0, 0,2'd0,0,0, 0,0);
    vecs[14] = mk(0,0,0,0,0, 32'd0, 1, 0,2'd0,0,0, 0,0);
    vecs[15] = mk(0,0,1,0,0, 32'd0, 1, 0,2'd0,0,0, 0,0);
    vecs[16] = mk(0,0,0,0,0, 32'd0, 1, 1,2'd2,0,0, 0,0);
    vecs[17] = mk(0,0,0,0,0, 32'd4, 1, 0,2'd0,0,0, 1,0);
    vecs[18] = mk(0,0,0,0,0, 32'd4, 1, 0,2'd0,0,0, 1,0);
    vecs[19] = mk(0,0,1,0,1, 32'd4, 1, 0,2'd0,0,0, 1,0);
    vecs[20] = mk(0,0,0,0,1, 32'd4, 1, 1,2'd2,0,0, 1,0);
    vecs[21] = mk(0,0,0,0,0, 32'd8, 1, 0,2'd0,0,0, 2,1);
    vecs[22] = mk(0,0,0,0,0, 32'd8, 1, 0,2'd0,0,0, 2,1);
    vecs[23] = mk(0,0,1,0,0, 32'd8, 1, 0,2'd0,0,0, 2,1);
    vecs[24] = mk(0,0,0,0,0, 32'd8, 1, 1,2'd2,0,0, 2,1);
    vecs[25] = mk(0,0,0,0,0, 32'd12,1, 0,2'd0,0,0, 3,1);
    vecs[26] = mk(0,1,1,0,0, 32'd12,1, 0,2'd0,0,0, 3,1);
    vecs[27] = mk(0,0,0,0,0, 32'd12,1, 1,2'd1,0,0, 3,1);
    vecs[28] = mk(0,0,0,1,0, 32'd16,1, 1,2'd1,0,0, 4,1);
    vecs[29] = mk(0,0,0,0,0, 32'd20,1, 0,2'd3,1,0, 5,1);

    $display("[TB] vector table on default-parameter instance");
    doReset;
    for (int i = 0; i < 30; i++) begin
      applyStimulus(vecs[i]);
      #1;
      if (vecs[i].chk) begin
        checkOutput($sformatf("v%0d core_en", i),   32'(en0), 32'(vecs[i].en));
        checkOutput($sformatf("v%0d state", i),     32'(st0), 32'(vecs[i].st));
        checkOutput($sformatf("v%0d halted", i),    32'(hl0), 32'(vecs[i].hl));
        checkOutput($sformatf("v%0d timeout", i),   32'(to0), 32'(vecs[i].to));
        checkOutput($sformatf("v%0d cycle_cnt", i), cc0, vecs[i].cc);
        checkOutput($sformatf("v%0d store_cnt", i), sc0, vecs[i].sc);
      end
      @(negedge clk);
    end

    $display("[TB] watchdog with TIMEOUT=10");
    doReset;
    run_req = 1'b1;
    @(negedge clk);
    run_req = 1'b0;
    n = 0;
    for (int i = 0; i < 40; i++) begin
      #1;
      if (hl1) break;
      if (en1) n++;
      instr_addr = instr_addr + 32'd4;
      @(negedge clk);
    end
    checkOutput("wd halted", 32'(hl1), 32'd1);
    checkOutput("wd exec cycles", 32'(n), 32'd10);
    checkOutput("wd state", 32'(st1), 32'd3);
    checkOutput("wd timeout", 32'(to1), 32'd1);
    checkOutput("wd cycle_cnt", cc1, 32'd10);
    checkOutput("wd default no timeout", 32'(to0), 32'd0);

    $display("[TB] halt together with run after 5 cycles");
    doReset;
    instr_addr = 32'd0;
    run_req = 1'b1;
    @(negedge clk);
    run_req = 1'b0;
    repeat (5) @(negedge clk);
    #1;
    checkOutput("halt pre cycle_cnt", cc0, 32'd5);
    checkOutput("halt pre core_en", 32'(en0), 32'd1);
    halt_req = 1'b1;
    run_req  = 1'b1;
    @(negedge clk);
    halt_req = 1'b0;
    run_req  = 1'b0;
    #1;
    checkOutput("halt state", 32'(st0), 32'd3);
    checkOutput("halt cycle_cnt", cc0, 32'd6);
    run_req = 1'b1;
    @(negedge clk);
    run_req  = 1'b0;
    step_req = 1'b1;
    @(negedge clk);
    step_req = 1'b0;
    #1;
    checkOutput("halt sticky state", 32'(st0), 32'd3);
    checkOutput("halt sticky core_en", 32'(en0), 32'd0);
    checkOutput("halt sticky cycle_cnt", cc0, 32'd6);

    $display("[TB] reset in the middle of a run");
    doReset;
    run_req = 1'b1;
    @(negedge clk);
    run_req = 1'b0;
    repeat (7) @(negedge clk);
    #1;
    checkOutput("mid-run cycle_cnt", cc0, 32'd7);
    checkOutput("mid-run state", 32'(st0), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #1;
    checkOutput("post-rst state", 32'(st0), 32'd0);
    checkOutput("post-rst cycle_cnt", cc0, 32'd0);
    checkOutput("post-rst core_en", 32'(en0), 32'd0);
    checkOutput("post-rst timeout", 32'(to0), 32'd0);
    checkOutput("post-rst wd timeout cleared", 32'(to1), 32'd0);

    $display("[TB] saturation with CNT_W=3");
    @(negedge clk);
    run_req = 1'b1;
    @(negedge clk);
    run_req = 1'b0;
    for (int i = 0; i < 15; i++) begin
      instr_addr = 32'(i * 4);
      @(negedge clk);
    end
    instr_addr = LAST;
    #1;
    checkOutput("sat core_en at LAST", 32'(en2), 32'd0);
    checkOutput("sat cycle_cnt", 32'(cc2), 32'd7);
    @(negedge clk);
    #1;
    checkOutput("sat state", 32'(st2), 32'd3);
    checkOutput("sat cycle_cnt held", 32'(cc2), 32'd7);
    checkOutput("sat timeout", 32'(to2), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, mismatchCount);
    $finish;
  end

endmodule
